// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the fetch stage and the decoder.
//   fetch_state_t : fetch sequencer states
//   SIZE_1..3     : instruction length encodings returned to the program counter
//   OPC_LEN_MSB   : upper bit of the two-bit length field inside the opcode
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_OP,
        CAP_OP,
        REQ_B1,
        CAP_B1,
        REQ_B2,
        CAP_B2,
        HOLD
    } fetch_state_t;

    localparam logic [1:0] SIZE_1 = 2'd1;
    localparam logic [1:0] SIZE_2 = 2'd2;
    localparam logic [1:0] SIZE_3 = 2'd3;

    localparam int OPC_LEN_MSB = 7;

endpackage

// File: rtl/instr_size_decode.sv
// instr_size_decode: combinational opcode length decode, shared with the decoder.
//   i_opcode  : opcode byte
//   o_size    : instruction length in bytes (1..3)
//   o_illegal : length field is the reserved encoding; reported as a 1-byte instruction
module instr_size_decode
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_opcode,
    output logic [1:0]            o_size,
    output logic                  o_illegal
);

    logic [1:0] w_len;

    assign w_len     = i_opcode[OPC_LEN_MSB -: 2];
    assign o_illegal = (w_len == 2'b11);
    assign o_size    = (w_len == 2'b01) ? SIZE_2 :
                       (w_len == 2'b10) ? SIZE_3 : SIZE_1;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetches a 1-3 byte instruction from program memory and hands it to the decoder.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_pc            : program counter, sampled when a fetch starts
//   i_fetch_start   : request a fetch at i_pc
//   i_flush         : abort any fetch or held instruction
//   o_mem_addr      : program memory address (base + byte offset, wrapping)
//   o_mem_rd_en     : program memory read enable
//   i_mem_rdata     : read data, one cycle after o_mem_rd_en
//   o_instr_valid   : assembled instruction available
//   i_instr_ready   : decoder accepts the instruction
//   o_opcode        : byte at the base address
//   o_operand1/2    : bytes at base+1 / base+2, zero when unused
//   o_instr_addr    : base address of the instruction
//   o_instr_size    : instruction length returned to the program counter
//   o_illegal       : opcode uses the reserved length encoding
//   o_busy          : fetch outstanding; halts the program counter
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic                  i_fetch_start,
    input  logic                  i_flush,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_rd_en,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready,
    output logic [DATA_WIDTH-1:0] o_opcode,
    output logic [DATA_WIDTH-1:0] o_operand1,
    output logic [DATA_WIDTH-1:0] o_operand2,
    output logic [ADDR_WIDTH-1:0] o_instr_addr,
    output logic [1:0]            o_instr_size,
    output logic                  o_illegal,
    output logic                  o_busy
);

    fetch_state_t          r_state;
    fetch_state_t          w_next;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [DATA_WIDTH-1:0] r_opcode;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;
    logic [1:0]            r_size;
    logic                  r_illegal;
    logic [1:0]            w_dec_size;
    logic                  w_dec_illegal;
    logic                  w_handshake;
    logic                  w_start;

    instr_size_decode #(.DATA_WIDTH(DATA_WIDTH)) u_size_decode (
        .i_opcode  (i_mem_rdata),
        .o_size    (w_dec_size),
        .o_illegal (w_dec_illegal)
    );

    assign w_handshake = (r_state == HOLD) && i_instr_ready;
    // A start is honoured only from IDLE or alongside a completing handshake; flush overrides it.
    assign w_start     = !i_flush && i_fetch_start && ((r_state == IDLE) || w_handshake);

    // The offset tracks the byte being read so the address stays a pure function of registers.
    assign w_offset = (r_state == REQ_B1 || r_state == CAP_B1) ? ADDR_WIDTH'(1) :
                      (r_state == REQ_B2 || r_state == CAP_B2) ? ADDR_WIDTH'(2) : '0;

    assign o_mem_addr    = r_base + w_offset;
    assign o_mem_rd_en   = (r_state == REQ_OP) || (r_state == REQ_B1) || (r_state == REQ_B2);
    assign o_instr_valid = (r_state == HOLD);
    assign o_busy        = (r_state != IDLE);
    assign o_opcode      = r_opcode;
    assign o_operand1    = r_op1;
    assign o_operand2    = r_op2;
    assign o_instr_addr  = r_base;
    assign o_instr_size  = r_size;
    assign o_illegal     = r_illegal;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? REQ_OP : IDLE;
            REQ_OP:  w_next = CAP_OP;
            CAP_OP:  w_next = (w_dec_size == SIZE_1) ? HOLD : REQ_B1;
            REQ_B1:  w_next = CAP_B1;
            CAP_B1:  w_next = (r_size == SIZE_3) ? REQ_B2 : HOLD;
            REQ_B2:  w_next = CAP_B2;
            CAP_B2:  w_next = HOLD;
            HOLD:    w_next = w_start ? REQ_OP : (w_handshake ? IDLE : HOLD);
            default: w_next = IDLE;
        endcase
        if (i_flush) w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_opcode  <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_size    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_base <= i_pc;
                r_op1  <= '0;
                r_op2  <= '0;
            end
            // Data returning for a flushed fetch is dropped.
            if (!i_flush) begin
                if (r_state == CAP_OP) begin
                    r_opcode  <= i_mem_rdata;
                    r_size    <= w_dec_size;
                    r_illegal <= w_dec_illegal;
                end
                if (r_state == CAP_B1) r_op1 <= i_mem_rdata;
                if (r_state == CAP_B2) r_op2 <= i_mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scoreboard bench for instr_fetch with a one-cycle-latency memory model.
module tb_instr_fetch;

    typedef struct {
        logic [7:0] opc;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [8:0] addr;
        logic [1:0] size;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [8:0] pc = '0;
    logic       fetch_start = 1'b0;
    logic       flush = 1'b0;
    logic [8:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata = '0;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [7:0] opcode;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic [8:0] instr_addr;
    logic [1:0] instr_size;
    logic       illegal;
    logic       busy;

    logic [7:0] mem [0:511];
    exp_t       exp_q[$];
    logic [8:0] rd_q[$];
    int         n_tests = 0;
    int         n_fail = 0;

    instr_fetch #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_pc          (pc),
        .i_fetch_start (fetch_start),
        .i_flush       (flush),
        .o_mem_addr    (mem_addr),
        .o_mem_rd_en   (mem_rd_en),
        .i_mem_rdata   (mem_rdata),
        .o_instr_valid (instr_valid),
        .i_instr_ready (instr_ready),
        .o_opcode      (opcode),
        .o_operand1    (operand1),
        .o_operand2    (operand2),
        .o_instr_addr  (instr_addr),
        .o_instr_size  (instr_size),
        .o_illegal     (illegal),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_rd_en"}, 32'(mem_rd_en), 32'h0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        check({tag, "_opcode"}, 32'(opcode), 32'h0);
        check({tag, "_op1"}, 32'(operand1), 32'h0);
        check({tag, "_op2"}, 32'(operand2), 32'h0);
        check({tag, "_instr_addr"}, 32'(instr_addr), 32'h0);
        check({tag, "_size"}, 32'(instr_size), 32'h0);
        check({tag, "_illegal"}, 32'(illegal), 32'h0);
    endtask

    // Loads memory, queues the expected instruction and read addresses, and raises fetch_start.
    task automatic push_fetch(input logic [8:0] a, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_t e;
        int   n;
        n = (b0[7:6] == 2'b01) ? 2 : (b0[7:6] == 2'b10) ? 3 : 1;
        mem[a] = b0;
        mem[9'(a + 1)] = b1;
        mem[9'(a + 2)] = b2;
        e.opc  = b0;
        e.op1  = (n > 1) ? b1 : 8'h00;
        e.op2  = (n > 2) ? b2 : 8'h00;
        e.addr = a;
        e.size = 2'(n);
        e.ill  = (b0[7:6] == 2'b11);
        exp_q.push_back(e);
        for (int k = 0; k < n; k++) rd_q.push_back(9'(a + k));
        pc = a;
        fetch_start = 1'b1;
    endtask

    task automatic wait_valid(output int lat, output int first_rd);
        logic [31:0] ea;
        lat = 0;
        first_rd = 0;
        while (lat < 20) begin
            tick();
            lat++;
            fetch_start = 1'b0;
            instr_ready = 1'b0;
            if (mem_rd_en) begin
                if (first_rd == 0) first_rd = lat;
                ea = 32'hFFFF_FFFF;
                if (rd_q.size() > 0) ea = 32'(rd_q.pop_front());
                check("rd_addr", 32'(mem_addr), ea);
            end
            if (instr_valid) break;
        end
        if (!instr_valid) check("valid_timeout", 32'(instr_valid), 32'h1);
    endtask

    task automatic check_instr(input int lat, input int first_rd);
        exp_t e;
        e = exp_q.pop_front();
        check("latency", 32'(lat), 32'(2 * e.size + 1));
        check("first_read_cycle", 32'(first_rd), 32'h1);
        check("opcode", 32'(opcode), 32'(e.opc));
        check("operand1", 32'(operand1), 32'(e.op1));
        check("operand2", 32'(operand2), 32'(e.op2));
        check("instr_addr", 32'(instr_addr), 32'(e.addr));
        check("instr_size", 32'(instr_size), 32'(e.size));
        check("illegal", 32'(illegal), 32'(e.ill));
        check("busy_hold", 32'(busy), 32'h1);
        check("reads_done", 32'(rd_q.size()), 32'h0);
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("valid_after_accept", 32'(instr_valid), 32'h0);
        check("busy_after_accept", 32'(busy), 32'h0);
    endtask

    initial begin
        int lat;
        int frd;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;

        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        push_fetch(9'h010, 8'h05, 8'h99, 8'h77);
        wait_valid(lat, frd);
        check_instr(lat, frd);
        accept();

        push_fetch(9'h1FE, 8'h80, 8'hAA, 8'h55);
        wait_valid(lat, frd);
        check_instr(lat, frd);
        accept();

        push_fetch(9'h030, 8'h41, 8'h77, 8'h66);
        wait_valid(lat, frd);
        check_instr(lat, frd);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(instr_valid), 32'h1);
            check("bp_opcode", 32'(opcode), 32'h41);
            check("bp_operand1", 32'(operand1), 32'h77);
            check("bp_size", 32'(instr_size), 32'h2);
            check("bp_addr", 32'(instr_addr), 32'h030);
        end
        instr_ready = 1'b1;
        push_fetch(9'h020, 8'h12, 8'h34, 8'h56);
        wait_valid(lat, frd);
        check_instr(lat, frd);
        accept();

        mem[9'h040] = 8'h5A;
        mem[9'h041] = 8'h33;
        pc = 9'h040;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("fl_req_op_addr", 32'(mem_addr), 32'h040);
        tick();
        tick();
        check("fl_req_b1_rd_en", 32'(mem_rd_en), 32'h1);
        check("fl_req_b1_addr", 32'(mem_addr), 32'h041);
        flush = 1'b1;
        fetch_start = 1'b1;
        pc = 9'h050;
        tick();
        flush = 1'b0;
        fetch_start = 1'b0;
        check("fl_busy", 32'(busy), 32'h0);
        check("fl_valid", 32'(instr_valid), 32'h0);
        check("fl_rd_en", 32'(mem_rd_en), 32'h0);
        check("fl_opcode_kept", 32'(opcode), 32'h5A);
        check("fl_size_kept", 32'(instr_size), 32'h2);
        check("fl_operand1", 32'(operand1), 32'h0);
        check("fl_instr_addr", 32'(instr_addr), 32'h040);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fl_idle_busy", 32'(busy), 32'h0);
            check("fl_idle_valid", 32'(instr_valid), 32'h0);
        end

        push_fetch(9'h060, 8'hC3, 8'h11, 8'h22);
        wait_valid(lat, frd);
        check_instr(lat, frd);
        accept();

        mem[9'h070] = 8'h9F;
        mem[9'h071] = 8'h01;
        mem[9'h072] = 8'h02;
        pc = 9'h070;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        repeat (3) tick();
        check("rst_mid_cap_b1_addr", 32'(mem_addr), 32'h071);
        check("rst_mid_cap_b1_rd_en", 32'(mem_rd_en), 32'h0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_valid", 32'(instr_valid), 32'h0);
            check("post_rst_busy", 32'(busy), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage between the program counter and the instruction decoder. On a start strobe it captures the current `pc` and reads the opcode byte from program memory. It determines the instruction length (1–3 bytes) from the opcode, reads any operand bytes, and presents the assembled instruction with a valid/ready handshake. It also returns `instr_size` to the program counter and stalls the program counter while a fetch is outstanding.

## Interface
Parameters:
- `ADDR_WIDTH`, default 9: program address width; must match the program counter.
- `DATA_WIDTH`, default 8: program memory byte width.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  in  ADDR_WIDTH  current program counter value; sampled on the `fetch_start` edge.
- `fetch_start`  in  1  request to fetch the instruction at `pc`.
- `flush`  in  1  abort any fetch or held instruction (jump taken).
- `mem_addr`  out  ADDR_WIDTH  program memory read address.
- `mem_rd_en`  out  1  program memory read enable.
- `mem_rdata`  in  DATA_WIDTH  read data; valid exactly one cycle after `mem_rd_en` is sampled high.
- `instr_valid`  out  1  assembled instruction available.
- `instr_ready`  in  1  decoder accepts the instruction.
- `opcode`  out  DATA_WIDTH  byte at the base address.
- `operand1`, `operand2`  out  DATA_WIDTH each  bytes at base+1 and base+2; zero if unused.
- `instr_addr`  out  ADDR_WIDTH  base address of the instruction.
- `instr_size`  out  2  length in bytes, 1..3; drives the program counter.
- `illegal`  out  1  opcode[7:6]==2'b11.
- `busy`  out  1  high in every state except IDLE; drives the program counter halt input.

## Operation
- Size decode from `opcode[7:6]`:
  - 00 → 1 byte
  - 01 → 2 bytes
  - 10 → 3 bytes
  - 11 → 1 byte with `illegal`=1
- States: IDLE, REQ_OP, CAP_OP, REQ_B1, CAP_B1, REQ_B2, CAP_B2, HOLD.
- IDLE: on `fetch_start`, latch `pc` into the base register, clear the operand registers, and go to REQ_OP.
- REQ_x states:
  - `mem_rd_en`=1.
  - `mem_addr` = base + offset (0, 1 or 2), truncated to ADDR_WIDTH, so 2^ADDR_WIDTH−1 + 1 wraps to 0.
  - Go to the matching CAP_x state.
- CAP_x states: `mem_rd_en`=0; capture `mem_rdata` into the matching byte register at the end of the cycle.
  - CAP_OP: decode size from `mem_rdata`; go to HOLD if size is 1, else REQ_B1.
  - CAP_B1: go to REQ_B2 if size is 3, else HOLD.
  - CAP_B2: go to HOLD.
- HOLD: `instr_valid`=1. All instruction outputs are stable until `instr_valid && instr_ready`.
  - Handshake without `fetch_start`: go to IDLE.
  - Handshake with `fetch_start` in the same cycle: latch the new `pc` and go directly to REQ_OP.
- `fetch_start` in any state other than IDLE or a completing HOLD is ignored.
- `flush` has priority over everything, including a simultaneous handshake and a simultaneous `fetch_start`:
  - Next state is IDLE and `instr_valid` drops.
  - Output registers keep their values.
  - A memory read in flight is discarded.
- `instr_size`, `illegal` and `opcode` are registered and update at the CAP_OP capture edge.
- Reset (asynchronous, any state, including mid-fetch): state IDLE, and all outputs 0, including `instr_size`, `mem_addr` and `mem_rd_en`.

## Timing
- Latency is counted from the edge that samples `fetch_start` (E0) to the first cycle with `instr_valid` high:
  - 1-byte instruction: 3 cycles
  - 2-byte instruction: 5 cycles
  - 3-byte instruction: 7 cycles
- Back-to-back: handshake plus `fetch_start` at edge En puts REQ_OP in cycle n+1. There is no IDLE bubble.
- `busy` rises the cycle after E0. It falls the cycle after a handshake that is not followed by a new fetch, or the cycle after a `flush`.
- All outputs are Moore and registered (or decoded from state only). There is no combinational path from inputs to outputs.

## Structure
- Shared package `cpu_pkg`:
  - state enum `fetch_state_t`
  - size encodings `SIZE_1`, `SIZE_2`, `SIZE_3`
  - opcode field position constant `OPC_LEN_MSB`=7
- Sub-module `instr_size_decode`: purely combinational, opcode → {size, illegal}. It is shared with the decoder.
- Remaining logic (state machine, byte registers, address adder) lives in `instr_fetch`, roughly 150–250 lines.

## Test plan
- Reset mid-fetch: assert `rst_n`=0 while in CAP_B1. → All outputs 0 immediately; state IDLE after release; no `instr_valid`.
- 1-byte fetch: memory[0x010]=0x05, `pc`=0x010, `fetch_start` pulse. → `mem_addr`=0x010 for one cycle; `instr_valid` 3 cycles later with `opcode`=0x05, `instr_size`=1, `operand1`=`operand2`=0.
- 3-byte fetch with wrap: `pc`=0x1FE, bytes 0x80, 0xAA, 0x55. → Reads at 0x1FE, 0x1FF, 0x000; valid at +7 cycles with `operand1`=0xAA, `operand2`=0x55, `instr_size`=3.
- Backpressure and back-to-back: hold `instr_ready`=0 for 5 cycles, then assert it together with `fetch_start` and `pc`=0x020. → Outputs stable throughout the hold; `mem_addr`=0x020 with `mem_rd_en`=1 in the very next cycle.
- Flush: assert `flush` during REQ_B1 of a 2-byte fetch, with `fetch_start` also high. → IDLE next cycle; `busy`=0; no `instr_valid`; the new start is ignored.
- Illegal opcode: opcode 0xC3. → `illegal`=1, `instr_size`=1, valid at +3 cycles.
